// File: rtl/sram_port_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals for sram_port_arbiter.
// slave = arbiter view; master = requesters plus the SRAM device.
interface sram_port_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  rw;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] addr2;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic [15:0] wdata2;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [15:0] rdata;
  logic        busy;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_read_ena;
  logic        sram_write_ena;
  logic [15:0] sram_rdata;

  modport slave (
    input  req, rw, addr0, addr1, addr2, wdata0, wdata1, wdata2, sram_rdata,
    output gnt, done, rdata, busy, sram_addr, sram_wdata, sram_read_ena, sram_write_ena
  );

  modport master (
    output req, rw, addr0, addr1, addr2, wdata0, wdata1, wdata2, sram_rdata,
    input  gnt, done, rdata, busy, sram_addr, sram_wdata, sram_read_ena, sram_write_ena
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Three-requester single-port SRAM arbiter: fixed priority bit0 > bit1 > bit2,
// or round-robin when SRAM_ARB_ROUND_ROBIN_EN is defined.
module sram_port_arbiter (
  input  logic                clk,
  input  logic                n_rst,
  sram_port_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ1 = 3'd1,
    READ2 = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [2:0]  gnt_q;
  logic        rw_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;

  logic        win_vld;
  logic [1:0]  win_idx;
  logic [2:0]  win_onehot;
  logic        win_rw;
  logic [15:0] win_addr;
  logic [15:0] win_wdata;

  assign win_vld = |bus.req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q;
  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  function automatic logic [1:0] next_of(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Search starts one past the last winner and wraps modulo 3.
  always_comb begin
    cand0   = next_of(ptr_q);
    cand1   = next_of(cand0);
    cand2   = next_of(cand1);
    win_idx = cand0;
    if (bus.req[cand0])      win_idx = cand0;
    else if (bus.req[cand1]) win_idx = cand1;
    else if (bus.req[cand2]) win_idx = cand2;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                        ptr_q <= 2'd0;
    else if (state == IDLE && win_vld) ptr_q <= win_idx;
  end
`else
  always_comb begin
    win_idx = 2'd0;
    if (bus.req[0])      win_idx = 2'd0;
    else if (bus.req[1]) win_idx = 2'd1;
    else if (bus.req[2]) win_idx = 2'd2;
  end
`endif

  always_comb begin
    win_addr  = bus.addr0;
    win_wdata = bus.wdata0;
    case (win_idx)
      2'd1: begin
        win_addr  = bus.addr1;
        win_wdata = bus.wdata1;
      end
      2'd2: begin
        win_addr  = bus.addr2;
        win_wdata = bus.wdata2;
      end
      default: ;
    endcase
  end

  assign win_rw     = bus.rw[win_idx];
  assign win_onehot = 3'b001 << win_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = win_rw ? WRITE : READ1;
      READ1:   state_nxt = READ2;
      READ2:   state_nxt = DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction context is captured once in IDLE; requester inputs are ignored afterwards.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gnt_q   <= 3'b000;
      rw_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      if (state == IDLE && win_vld) begin
        gnt_q   <= win_onehot;
        rw_q    <= win_rw;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
      end else if (state == DONE) begin
        gnt_q   <= 3'b000;
      end
      if (state == READ2) rdata_q <= bus.sram_rdata;
    end
  end

  always_comb begin
    bus.gnt            = gnt_q;
    bus.done           = (state == DONE) ? gnt_q : 3'b000;
    bus.rdata          = rdata_q;
    bus.busy           = (state != IDLE);
    bus.sram_addr      = (state != IDLE) ? addr_q  : 16'h0000;
    bus.sram_wdata     = (state != IDLE) ? wdata_q : 16'h0000;
    // Qualifying with rw_q keeps the two enables mutually exclusive by construction.
    bus.sram_read_ena  = ((state == READ1) || (state == READ2)) && !rw_q;
    bus.sram_write_ena = (state == WRITE) && rw_q;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model (honours SRAM_ARB_ROUND_ROBIN_EN).
module tb_sram_port_arbiter;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter_if bus();

  sram_port_arbiter dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // SRAM device model: combinational read, write on the clock edge.
  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];
  assign bus.sram_rdata = bus.sram_read_ena ? mem[bus.sram_addr] : 16'h0000;
  always @(posedge clk) if (bus.sram_write_ena) mem[bus.sram_addr] <= bus.sram_wdata;

  int          checks = 0;
  int          errors = 0;
  int          ptr    = 0;
  logic [15:0] last_rdata = 16'h0000;

  logic [2:0]  rq;
  logic [2:0]  rwv;
  logic [15:0] a  [3];
  logic [15:0] wd [3];

  task automatic apply();
    bus.req    = rq;
    bus.rw     = rwv;
    bus.addr0  = a[0];
    bus.addr1  = a[1];
    bus.addr2  = a[2];
    bus.wdata0 = wd[0];
    bus.wdata1 = wd[1];
    bus.wdata2 = wd[2];
  endtask

  // Reference arbitration: fixed lowest-index-first, or rotating from last winner + 1.
  function automatic int pick(input logic [2:0] r);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) if (r[(ptr + k) % 3]) return (ptr + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  function automatic logic [40:0] obs();
    return {bus.gnt, bus.done, bus.busy, bus.sram_read_ena, bus.sram_write_ena,
            bus.sram_addr, bus.sram_wdata};
  endfunction

  // Runs one arbitration slot from an IDLE cycle; inputs must already be applied.
  task automatic run_txn(input string name, input logic [2:0] req_mid, output logic [2:0] obs_gnt);
    int          w;
    int          n;
    logic [2:0]  eg;
    logic        erw;
    logic [15:0] ea;
    logic [15:0] ew;
    logic [15:0] er;
    logic [40:0] exp_v;
    logic [40:0] act_v;
    obs_gnt = 3'b000;
    w = pick(rq);
    if (w < 0) begin
      @(negedge clk);
      checks++;
      if (obs() !== 41'd0 || bus.rdata !== last_rdata) begin
        errors++;
        $display("FAIL %s idle-stay: got %h rdata %h expected 0 rdata %h", name, obs(), bus.rdata, last_rdata);
      end
      return;
    end
    eg  = 3'b001 << w;
    erw = rwv[w];
    ea  = a[w];
    ew  = wd[w];
    ptr = w;
    n   = erw ? 2 : 3;
    if (!erw) last_rdata = ref_mem[ea];
    er  = last_rdata;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      exp_v = {eg, (c == n) ? eg : 3'b000, 1'b1, !erw && (c < n), erw && (c == 1), ea, ew};
      act_v = obs();
      if (c == 1) obs_gnt = bus.gnt;
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, act_v, exp_v);
      end
      if (c == n) begin
        checks++;
        if (bus.rdata !== er) begin
          errors++;
          $display("FAIL %s rdata: got %h expected %h", name, bus.rdata, er);
        end
      end
      if (c == 1) begin
        rq = req_mid;
        for (int i = 0; i < 3; i++) begin
          if (i != w) begin
            a[i]   = 16'($urandom);
            wd[i]  = 16'($urandom);
            rwv[i] = 1'($urandom);
          end
        end
        apply();
      end
    end
    if (erw) ref_mem[ea] = ew;
    @(negedge clk);
    checks++;
    if (obs() !== 41'd0 || bus.rdata !== last_rdata) begin
      errors++;
      $display("FAIL %s return-to-idle: got %h rdata %h expected 0 rdata %h", name, obs(), bus.rdata, last_rdata);
    end
  endtask

  task automatic test_reset();
    rq = 3'b111; rwv = 3'b000;
    for (int i = 0; i < 3; i++) begin a[i] = 16'h1111; wd[i] = 16'h2222; end
    apply();
    #3;
    checks++;
    if (obs() !== 41'd0 || bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset: got %h rdata %h expected 0", obs(), bus.rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 41'd0) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0", obs());
    end
    @(negedge clk);
    rq = 3'b000;
    apply();
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 41'd0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected 0", obs());
    end
  endtask

  task automatic test_single_read();
    logic [2:0] g;
    mem[16'h0040]     = 16'hBEEF;
    ref_mem[16'h0040] = 16'hBEEF;
    rq = 3'b010; rwv = 3'b000; a[1] = 16'h0040;
    apply();
    run_txn("single_read", 3'b010, g);
    checks++;
    if (bus.rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_read_hold: got %h expected beef", bus.rdata);
    end
  endtask

  task automatic test_single_write();
    logic [2:0] g;
    rq = 3'b001; rwv = 3'b001; a[0] = 16'h0007; wd[0] = 16'h1234;
    apply();
    run_txn("single_write", 3'b001, g);
    checks++;
    if (mem[16'h0007] !== 16'h1234) begin
      errors++;
      $display("FAIL single_write_mem: got %h expected 1234", mem[16'h0007]);
    end
  endtask

  task automatic test_contention();
    logic [2:0] g;
    logic [2:0] seq [4];
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    seq = '{3'b010, 3'b100, 3'b001, 3'b010};
`else
    seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    for (int t = 0; t < 4; t++) begin
      rq = 3'b111; rwv = 3'b000;
      for (int i = 0; i < 3; i++) a[i] = 16'($urandom);
      apply();
      run_txn("contention", 3'b111, g);
      checks++;
      if (g !== seq[t]) begin
        errors++;
        $display("FAIL contention_order #%0d: got %b expected %b", t, g, seq[t]);
      end
    end
  endtask

  task automatic test_abort();
    logic [2:0] g;
    rq = 3'b001; rwv = 3'b000; a[0] = 16'($urandom);
    apply();
    @(negedge clk);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 41'd0 || bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL abort_async: got %h rdata %h expected 0", obs(), bus.rdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 41'd0) begin
      errors++;
      $display("FAIL abort_no_done: got %h expected 0", obs());
    end
    @(negedge clk);
    ptr = 0;
    last_rdata = 16'h0000;
    rq = 3'b100; rwv = 3'b000; a[2] = 16'($urandom);
    apply();
    n_rst = 1'b1;
    run_txn("after_abort", 3'b100, g);
  endtask

  task automatic test_req_drop();
    logic [2:0] g;
    rq = 3'b010; rwv = 3'b010; a[1] = 16'($urandom); wd[1] = 16'($urandom);
    apply();
    run_txn("req_drop", 3'b000, g);
  endtask

  task automatic test_back_to_back_random();
    logic [2:0] g;
    for (int t = 0; t < 150; t++) begin
      rq  = 3'($urandom);
      rwv = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        a[i]  = 16'($urandom);
        wd[i] = 16'($urandom);
      end
      if (t % 5 == 0) a[$urandom_range(0, 2)] = a[0];
      apply();
      run_txn("random", 3'($urandom), g);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i) ^ 16'hA5A5;
      ref_mem[i] = 16'(i) ^ 16'hA5A5;
    end
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_abort();
    test_req_drop();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  system clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- req  in  3  access requests; bit0 = sample loader, bit1 = FFT MCU, bit2 = sample unloader
- rw  in  3  per-requester access type; 1 = write, 0 = read
- addr0/addr1/addr2  in  16 each  per-requester SRAM word address
- wdata0/wdata1/wdata2  in  16 each  per-requester write data
- gnt  out  3  one-hot grant; held for the whole transaction
- done  out  3  one-hot, one-cycle completion pulse
- rdata  out  16  registered read data; valid when done is high for a read
- busy  out  1  high in any state other than IDLE
- sram_addr  out  16  SRAM address
- sram_wdata  out  16  SRAM write data
- sram_read_ena  out  1  SRAM read enable
- sram_write_ena  out  1  SRAM write enable
- sram_rdata  in  16  SRAM read data
REQ-002 SHALL use one clock, clk; reset SHALL be asynchronous and active-low, on n_rst.

Function
REQ-003 SHALL implement the FSM states IDLE, READ1, READ2, WRITE and DONE.
REQ-004 In IDLE with req != 0, SHALL on the next edge:
- select one winner
- register gnt, the winner's rw, addr and wdata
- enter READ1 if the winner's rw = 0, or WRITE if rw = 1
REQ-005 In IDLE with req == 0, SHALL remain in IDLE with gnt = 0.
REQ-006 READ1 -> READ2 -> DONE; sram_read_ena SHALL be 1 in READ1 and READ2, for the 2-cycle SRAM read latency.
REQ-007 rdata SHALL capture sram_rdata on the edge leaving READ2; rdata SHALL hold its value until the next read completes.
REQ-008 WRITE -> DONE; sram_write_ena SHALL be 1 for exactly one cycle, in WRITE.
REQ-009 DONE SHALL:
- assert done = gnt for one cycle
- return to IDLE
- keep gnt asserted during DONE and clear it on entry to IDLE
REQ-010 Latency from IDLE sampling req to the done pulse SHALL be 3 cycles for a read and 2 cycles for a write; there SHALL be 1 IDLE cycle between back-to-back transactions.
REQ-011 sram_addr and sram_wdata SHALL drive the latched values in all non-IDLE states and 0 in IDLE.
REQ-012 sram_read_ena and sram_write_ena SHALL never be high in the same cycle.
REQ-013 A requester SHALL hold req, rw, addr and wdata until its done pulse.
REQ-014 Deassertion of the granted req mid-transaction SHALL be ignored; the transaction SHALL complete and done SHALL still pulse.
REQ-015 Changes on non-granted req bits during a transaction SHALL be ignored until the next IDLE.
REQ-016 Default arbitration SHALL be fixed priority: bit0 > bit1 > bit2.
REQ-017 A requester whose req stays high SHALL be re-arbitrated in IDLE and MAY win consecutive transactions.

Reset
REQ-018 On n_rst = 0, SHALL immediately force:
- state = IDLE
- gnt = 0, done = 0, rdata = 0, busy = 0
- sram_read_ena = 0, sram_write_ena = 0
- sram_addr = 0, sram_wdata = 0
- latched rw/addr/wdata = 0
- round-robin pointer = 0 (when compiled in)
REQ-019 Reset asserted mid-transaction SHALL abort it with no done pulse; after reset release, arbitration SHALL restart from IDLE.

Configuration
REQ-020 With macro SRAM_ARB_ROUND_ROBIN_EN defined:
- SHALL keep a 2-bit pointer to the last granted requester, reset value 0
- priority SHALL rotate, starting at pointer+1 modulo 3
- the pointer SHALL update on the edge leaving IDLE with a grant
- after reset, the first arbitration order SHALL be bit1 > bit2 > bit0
REQ-021 Without SRAM_ARB_ROUND_ROBIN_EN, SHALL use the fixed priority of REQ-016 and SHALL contain no pointer register.

Verification
REQ-022 Single read: req = 3'b010, rw = 0, addr1 = 16'h0040, sram_rdata = 16'hBEEF -> gnt = 3'b010 one cycle after sampling; sram_read_ena high 2 cycles; done = 3'b010 on cycle 3 with rdata = 16'hBEEF.
REQ-023 Single write: req = 3'b001, rw = 3'b001, addr0 = 16'h0007, wdata0 = 16'h1234 -> sram_write_ena high 1 cycle with sram_addr = 16'h0007 and sram_wdata = 16'h1234; done = 3'b001 on cycle 2.
REQ-024 Contention, fixed priority: req = 3'b111 held, all reads -> grants in order 001, 001, 001, ...; bit1 and bit2 are never granted while bit0 is held.
REQ-025 Contention, SRAM_ARB_ROUND_ROBIN_EN defined: req = 3'b111 held, all reads -> grant order 010, 100, 001, 010.
REQ-026 Mid-transaction abort: n_rst low during READ2 -> all outputs 0 asynchronously, no done pulse; after release with req = 3'b100, rw = 0 -> a normal 3-cycle read completes.
REQ-027 Request dropped: req1 falls during WRITE -> done = 3'b010 still pulses; the FSM returns to IDLE with gnt = 0.
